// File: rtl/activation_seq_ctrl.sv
// Activation tile sequencer: streams NUM_PE-wide vectors from the input
// feature buffer through the ReLU6 PE bank into the output buffer.
module activation_seq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12,
  parameter int NUM_PE = 4,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_src_base,
  input  logic [ADDR_W-1:0] i_cmd_dst_base,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_out_stall,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_pe_start,
  output logic              o_pe_enable,
  input  logic              i_pe_flag,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("RD_LAT must be at least 1");
  end
  if (NUM_PE < 1) begin : g_bad_num_pe
    $error("NUM_PE must be at least 1");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issue_cnt;
  logic [LEN_W-1:0]  r_wr_cnt;
  logic              r_cmd_ready;
  logic [RD_LAT-1:0] r_en_sr;

  logic w_accept;
  logic w_busy;
  logic w_rd_en;
  logic w_wr_en;
  logic w_last_issue;
  logic w_last_wr;

  assign w_accept = i_cmd_valid & r_cmd_ready;
  assign w_busy   = (r_state == S_RUN) |
                    (r_state == S_DRAIN);
  assign w_rd_en  = (r_state == S_RUN) &
                    ~i_out_stall;
  assign w_wr_en  = i_pe_flag & w_busy;

  assign w_last_issue = w_rd_en &
    (r_issue_cnt == r_len - LEN_W'(1));
  assign w_last_wr = w_wr_en &
    (r_wr_cnt == r_len - LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_accept)
          w_state_nxt = (i_cmd_len == '0) ?
                        S_DONE : S_RUN;
      end
      (r_state == S_RUN): begin
        if (w_last_issue)
          w_state_nxt = S_DRAIN;
      end
      (r_state == S_DRAIN): begin
        if (w_last_wr)
          w_state_nxt = S_DONE;
      end
      (r_state == S_DONE): begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ready is registered so it rises one cycle after IDLE is re-entered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_en_sr     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (r_state == S_IDLE) &
                     ~w_accept;
      if (w_accept) begin
        r_src       <= i_cmd_src_base;
        r_dst       <= i_cmd_dst_base;
        r_len       <= i_cmd_len;
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
      end else begin
        if (w_rd_en)
          r_issue_cnt <= r_issue_cnt +
                         LEN_W'(1);
        if (w_wr_en)
          r_wr_cnt <= r_wr_cnt + LEN_W'(1);
      end
      if (w_busy)
        r_en_sr <= (r_en_sr << 1) |
                   RD_LAT'(w_rd_en);
      else
        r_en_sr <= '0;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rd_en     = w_rd_en;
  assign o_rd_addr   = r_src +
                       ADDR_W'(r_issue_cnt);
  assign o_pe_start  = w_busy;
  assign o_pe_enable = r_en_sr[RD_LAT-1] &
                       w_busy;
  assign o_wr_en     = w_wr_en;
  assign o_wr_addr   = r_dst +
                       ADDR_W'(r_wr_cnt);
  assign o_busy      = w_busy;
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_activation_seq_ctrl.sv
// Self-checking bench for activation_seq_ctrl: per-command expected
// read/write/done timelines computed from issue slots and compared each cycle.
module tb_activation_seq_ctrl;

  localparam int AW   = 12;
  localparam int LW   = 12;
  localparam int RDL  = 2;
  localparam int MAXJ = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pe_start;
  logic          pe_enable;
  logic          pe_flag = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_bad = 0;

  activation_seq_ctrl #(
    .ADDR_W(AW), .LEN_W(LW),
    .NUM_PE(4), .RD_LAT(RDL)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_src_base(src),
    .i_cmd_dst_base(dst),
    .i_cmd_len     (len),
    .i_out_stall   (stall),
    .o_rd_en       (rd_en),
    .o_rd_addr     (rd_addr),
    .o_pe_start    (pe_start),
    .o_pe_enable   (pe_enable),
    .i_pe_flag     (pe_flag),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // PE bank: result valid one cycle after enable, cleared while not started
  always @(posedge clk)
    pe_flag <= pe_start & pe_enable;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] s,
                         input logic [AW-1:0] d,
                         input logic [LW-1:0] n,
                         input int mode,
                         input bit hold);
    bit            st  [MAXJ];
    bit            erd [MAXJ];
    bit            ewr [MAXJ];
    logic [AW-1:0] era [MAXJ];
    logic [AW-1:0] ewa [MAXJ];
    int issued;
    int last;
    int dj;
    for (int j = 0; j < MAXJ; j++) begin
      case (mode)
        1: st[j] = (j >= 2 && j <= 4);
        2: st[j] = (j < 40) &&
                   ($urandom_range(0, 3) == 0);
        default: st[j] = 1'b0;
      endcase
      erd[j] = 1'b0;
      ewr[j] = 1'b0;
      era[j] = '0;
      ewa[j] = '0;
    end
    issued = 0;
    last   = 0;
    for (int j = 0; j < MAXJ - RDL - 2 && issued < int'(n); j++)
      if (!st[j]) begin
        erd[j]         = 1'b1;
        era[j]         = s + AW'(issued);
        ewr[j+RDL+1]   = 1'b1;
        ewa[j+RDL+1]   = d + AW'(issued);
        issued++;
        last = j;
      end
    dj = (n == 0) ? 0 : last + RDL + 2;

    cmd_valid = 1'b1;
    src = s;
    dst = d;
    len = n;
    check("ready_before_cmd", cmd_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int j = 0; j <= dj + 2; j++) begin
      stall = st[j];
      @(negedge clk);
      check("rd_en", rd_en, erd[j]);
      if (erd[j]) check("rd_addr", rd_addr, era[j]);
      check("wr_en", wr_en, ewr[j]);
      if (ewr[j]) check("wr_addr", wr_addr, ewa[j]);
      check("done", done, j == dj);
      check("busy", busy, n != 0 && j < dj);
      check("pe_start", pe_start, n != 0 && j < dj);
      check("cmd_ready", cmd_ready, j == dj + 2);
      if (j < dj + 2) begin
        @(posedge clk);
        #1;
      end
    end
    stall = 1'b0;
  endtask

  task automatic reset_mid_run;
    cmd_valid = 1'b1;
    src = 12'h100;
    dst = 12'h300;
    len = 12'd8;
    stall = 1'b0;
    check("rst_ready_before", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_rd0", rd_en, 1);
    check("rst_rd0_addr", rd_addr, 12'h100);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rd1", rd_en, 1);
    check("rst_rd1_addr", rd_addr, 12'h101);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_before", busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_pe_start", pe_start, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_pe_enable", pe_enable, 0);
    check("rst_wr_en_after", wr_en, 0);
  endtask

  initial begin
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    logic [LW-1:0] rn;
    rst = 1'b1;
    cmd_valid = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_rd_en", rd_en, 0);
    check("reset_pe_start", pe_start, 0);
    check("reset_pe_enable", pe_enable, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_addr", wr_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    run_cmd(12'h010, 12'h200, 12'd4, 0, 1'b0);
    run_cmd(12'h055, 12'h066, 12'd0, 0, 1'b0);
    run_cmd(12'h020, 12'h400, 12'd8, 1, 1'b0);
    run_cmd(12'hFFE, 12'hFFD, 12'd4, 0, 1'b0);
    reset_mid_run();
    run_cmd(12'h030, 12'h500, 12'd2, 0, 1'b0);
    run_cmd(12'h040, 12'h600, 12'd5, 2, 1'b1);
    run_cmd(12'h040, 12'h600, 12'd5, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      rs = AW'($urandom);
      rd = AW'($urandom);
      rn = LW'($urandom_range(0, 12));
      run_cmd(rs, rd, rn, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
